psum_quant_packer: RTL and testbench
====================================

# psum_quant_packer

Parametrised requantizer and packer for PE-array partial sums. Sits between the core's psum output and the activation buffer write port. Each input beat carries NUM_CH signed partial sums; the block applies optional ReLU, a rounded right shift and saturation to the next layer's input precision (2/4/8/16 bit). It packs successive beats into full-width words and buffers them in an output FIFO with valid/ready handshakes on both sides.

## Interface
- NUM_CH, 8, channels per beat
- PSUM_W, 28, signed psum width per channel
- OUT_W, 16, max precision; output lane width (word = NUM_CH*OUT_W bits)
- SHIFT_W, 4, width of shift amount
- FIFO_DEPTH, 4, output FIFO entries (>= 2)
- CLK  in  1  clock, all state on rising edge
- RST  in  1  asynchronous active-low reset
- i_Vld  in  1  input beat valid
- i_Rdy  out  1  block can accept a beat
- i_Psum  in  NUM_CH*PSUM_W  channel c at [c*PSUM_W +: PSUM_W], two's complement
- i_Precision  in  2  00=2b, 01=4b, 10=8b, 11=16b
- i_Shift  in  SHIFT_W  right-shift amount
- i_Relu  in  1  clamp negatives to 0, unsigned saturation
- i_Last  in  1  final beat of tile; flush partial word
- i_Layer  in  5  layer number, carried with word
- i_Clr  in  1  synchronous clear of o_SatCnt
- o_Vld  out  1  output word valid
- o_Rdy  in  1  consumer ready
- o_Data  out  NUM_CH*OUT_W  packed word
- o_Layer  out  5  layer of o_Data word
- o_SatCnt  out  16  saturated channel-beats since reset/clear

## Operation
- Transfer on i_Vld&i_Rdy (input) and o_Vld&o_Rdy (output). i_Psum/i_Shift/i_Relu sampled every accepted beat; i_Precision and i_Layer latched on the first beat of a word (pack index 0), ignored on later beats of that word.
- Stage 1 (quantize, registered), per channel x: if i_Relu and x<0, x=0. y = (x + (s>0 ? 2^(s-1) : 0)) >>> s, computed in PSUM_W+1 bits, no overflow. Saturate to p bits: i_Relu → [0, 2^p-1]; else → [-2^(p-1), 2^(p-1)-1]. Field = low p bits of saturated value.
- Stage 2 (pack): beats per word B = OUT_W/p (1/2/4/8 at defaults). Beat k of a word placed at [k*NUM_CH*p +: NUM_CH*p]; channel c at offset c*p within that slice. Word complete when k = B-1 or beat has i_Last; complete word written to FIFO with latched layer, pack index returns to 0. Unfilled bits of a flushed word are 0.
- o_SatCnt += number of channels saturated in each accepted beat (count only where the clamp changed the value; ReLU zeroing is not saturation); sticks at 16'hFFFF. i_Clr zeroes it; if i_Clr and an increment coincide, result is the increment alone.
- i_Rdy = (fifo_count <= FIFO_DEPTH-2), from registered count; guarantees room for the in-flight stage-1 word. Simultaneous push/pop legal at any count. No word dropped or reordered.
- o_Data/o_Layer hold while o_Vld&!o_Rdy.

## Timing
- Reset (RST low, async): o_Vld=0, o_Data=0, o_Layer=0, o_SatCnt=0, FIFO empty, pack index 0, stage-1 valid 0; i_Rdy=1 once RST high. Reset mid-word discards the partial word and all FIFO contents.
- Latency: a word-completing beat accepted in cycle t with FIFO empty → o_Vld=1 in cycle t+2.
- Throughput: one beat per cycle while i_Rdy=1; one word per cycle out.
- i_Last on first beat of a word emits a single-beat word at any precision.

## Test plan
- 16b, shift=2, relu=0, ch0=13, ch1=-13, others 0, one beat at t → o_Vld at t+2, lane0=16'h0003, lane1=16'hFFFD, o_SatCnt=0.
- 8b, relu=0, shift=0, ch0=1000, ch1=-1000, two beats (second all 1) → one word; beat0 bytes 8'h7F,8'h80; beat1 bytes 8'h01 at bits [64+:8]..; o_SatCnt=2.
- 2b, relu=1, shift=0, 8 beats, ch values {0,1,2,3,5,-4,3,0} → one word, fields 0,1,2,3,3,0,3,0 per beat; o_SatCnt=8; i_Layer changed on beat 3 does not alter o_Layer.
- 4b, i_Last on 3rd beat → word emitted after 3 beats, bits [127:96]=0; next beat starts at index 0 with newly latched precision.
- o_Rdy=0, stream 16b beats back-to-back → exactly FIFO_DEPTH words accepted, i_Rdy low after; raise o_Rdy → words out in order, no loss, i_Rdy reasserts.
- RST low after 1 of 2 8b beats with FIFO holding 2 words → all outputs 0 immediately; after release a fresh 2-beat word emits correctly.

Source files
------------

// File: rtl/psum_quant_packer_if.sv
`default_nettype none
// ==========================================================================
// Interface : psum_quant_packer_if
// Purpose   : Input beat and output word handshake bundle for the psum
//             requantizer / packer.
// Revision  : 1.0  initial release
// ==========================================================================
interface psum_quant_packer_if #(
  parameter int NUM_CH  = 8,
  parameter int PSUM_W  = 28,
  parameter int OUT_W   = 16,
  parameter int SHIFT_W = 4
);
  logic                       i_Vld;
  logic                       i_Rdy;
  logic [NUM_CH*PSUM_W-1:0]   i_Psum;
  logic [1:0]                 i_Precision;
  logic [SHIFT_W-1:0]         i_Shift;
  logic                       i_Relu;
  logic                       i_Last;
  logic [4:0]                 i_Layer;
  logic                       i_Clr;
  logic                       o_Vld;
  logic                       o_Rdy;
  logic [NUM_CH*OUT_W-1:0]    o_Data;
  logic [4:0]                 o_Layer;
  logic [15:0]                o_SatCnt;

  // Block side
  modport slave (
    input  i_Vld, i_Psum, i_Precision, i_Shift, i_Relu, i_Last, i_Layer, i_Clr,
    input  o_Rdy,
    output i_Rdy, o_Vld, o_Data, o_Layer, o_SatCnt
  );

  // Producer / consumer side
  modport master (
    output i_Vld, i_Psum, i_Precision, i_Shift, i_Relu, i_Last, i_Layer, i_Clr,
    output o_Rdy,
    input  i_Rdy, o_Vld, o_Data, o_Layer, o_SatCnt
  );
endinterface
`default_nettype wire

// File: rtl/psum_quant_packer.sv
`default_nettype none
// ==========================================================================
// Module   : psum_quant_packer
// Purpose  : Optional ReLU, rounded right shift and saturation of PE partial
//            sums to 2/4/8/16 bit, packing of beats into full words and an
//            output word FIFO with valid/ready on both sides.
// Revision : 1.0  initial release
// ==========================================================================
module psum_quant_packer #(
  parameter int NUM_CH     = 8,
  parameter int PSUM_W     = 28,
  parameter int OUT_W      = 16,
  parameter int SHIFT_W    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               CLK,
  input  logic               RST,
  psum_quant_packer_if.slave bus
);
  localparam int WORD_W = NUM_CH * OUT_W;
  localparam int IDX_W  = (OUT_W > 2) ? $clog2(OUT_W / 2) : 1;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int SATN_W = $clog2(NUM_CH + 1);
  localparam int Y_W    = PSUM_W + 1;

  // Input-side word tracking
  logic [IDX_W-1:0]      pack_idx_q, pack_idx_d;
  logic [1:0]            prec_lat_q;
  logic [4:0]            layer_lat_q;
  logic [15:0]           sat_cnt_q, sat_cnt_d;

  // Stage 1: one quantized beat already placed at its word position
  logic                  s1_vld_q;
  logic                  s1_done_q;
  logic [WORD_W-1:0]     s1_slice_q;
  logic [4:0]            s1_layer_q;

  // Stage 2: partial word accumulator and FIFO
  logic [WORD_W-1:0]     word_q;
  logic [WORD_W-1:0]     mem_q [FIFO_DEPTH];
  logic [4:0]            lmem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic                  w_accept;
  logic [1:0]            w_prec;
  logic [4:0]            w_layer;
  int                    w_p;
  logic [IDX_W-1:0]      w_beats_m1;
  logic                  w_done;
  logic [OUT_W-1:0]      w_mask;
  logic signed [Y_W-1:0] w_lim_hi, w_lim_lo, w_round;
  logic [OUT_W-1:0]      w_field [NUM_CH];
  logic [NUM_CH-1:0]     w_sat;
  logic [WORD_W-1:0]     w_beat, w_slice, w_word;
  logic [SATN_W-1:0]     w_sat_num;
  logic [16:0]           w_sat_sum;
  logic                  w_push, w_pop, w_nonempty;

  assign w_accept   = bus.i_Vld && bus.i_Rdy;
  assign w_nonempty = (cnt_q != '0);
  assign w_push     = s1_vld_q && s1_done_q;
  assign w_pop      = w_nonempty && bus.o_Rdy;
  assign w_word     = word_q | s1_slice_q;

  // Precision/layer come from the live inputs only on the first beat of a word
  always_comb begin
    w_prec     = (pack_idx_q == '0) ? bus.i_Precision : prec_lat_q;
    w_layer    = (pack_idx_q == '0) ? bus.i_Layer : layer_lat_q;
    w_p        = 2 << w_prec;
    w_beats_m1 = IDX_W'((OUT_W >> (int'(w_prec) + 1)) - 1);
    w_done     = (pack_idx_q == w_beats_m1) || bus.i_Last;
    w_mask     = OUT_W'((1 << w_p) - 1);
    if (bus.i_Relu) begin
      w_lim_hi = Y_W'((1 << w_p) - 1);
      w_lim_lo = '0;
    end else begin
      w_lim_hi = Y_W'((1 << (w_p - 1)) - 1);
      w_lim_lo = Y_W'(-(1 << (w_p - 1)));
    end
    w_round = (bus.i_Shift != '0) ? (Y_W'(1) << (bus.i_Shift - SHIFT_W'(1))) : '0;
  end

  // Per-channel ReLU, round-half-up shift and clamp; one extra bit keeps the
  // rounding add from overflowing
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic signed [PSUM_W-1:0] w_x;
    logic signed [Y_W-1:0]    w_xr, w_y, w_clamp;
    logic                     w_hi, w_lo;

    assign w_x        = bus.i_Psum[c*PSUM_W +: PSUM_W];
    assign w_xr       = (bus.i_Relu && w_x[PSUM_W-1]) ? '0 : {w_x[PSUM_W-1], w_x};
    assign w_y        = (w_xr + w_round) >>> bus.i_Shift;
    assign w_hi       = (w_y > w_lim_hi);
    assign w_lo       = (w_y < w_lim_lo);
    assign w_clamp    = w_hi ? w_lim_hi : (w_lo ? w_lim_lo : w_y);
    assign w_field[c] = OUT_W'(w_clamp) & w_mask;
    assign w_sat[c]   = w_hi | w_lo;
  end

  // Gather channel fields into a beat slice and move it to its word position
  always_comb begin
    w_beat    = '0;
    w_sat_num = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_beat    = w_beat | (WORD_W'(w_field[c]) << (c * w_p));
      w_sat_num = w_sat_num + SATN_W'(w_sat[c]);
    end
    w_slice = w_beat << (int'(pack_idx_q) * NUM_CH * w_p);
  end

  // Next pack index and saturating saturation counter (clear keeps only the
  // increment of the same cycle)
  always_comb begin
    pack_idx_d = pack_idx_q;
    if (w_accept) pack_idx_d = w_done ? '0 : pack_idx_q + IDX_W'(1);
    w_sat_sum = {1'b0, sat_cnt_q} + (w_accept ? 17'(w_sat_num) : 17'd0);
    if (bus.i_Clr)       sat_cnt_d = w_accept ? 16'(w_sat_num) : 16'd0;
    else if (w_sat_sum[16]) sat_cnt_d = 16'hFFFF;
    else                 sat_cnt_d = w_sat_sum[15:0];
    cnt_d = cnt_q;
    if (w_push && !w_pop)      cnt_d = cnt_q + CNT_W'(1);
    else if (!w_push && w_pop) cnt_d = cnt_q - CNT_W'(1);
  end

  // Input tracking, stage-1 register and pack accumulator
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pack_idx_q  <= '0;
      prec_lat_q  <= '0;
      layer_lat_q <= '0;
      sat_cnt_q   <= '0;
      s1_vld_q    <= 1'b0;
      s1_done_q   <= 1'b0;
      s1_slice_q  <= '0;
      s1_layer_q  <= '0;
      word_q      <= '0;
    end else begin
      pack_idx_q <= pack_idx_d;
      sat_cnt_q  <= sat_cnt_d;
      s1_vld_q   <= w_accept;
      if (w_accept && pack_idx_q == '0) begin
        prec_lat_q  <= bus.i_Precision;
        layer_lat_q <= bus.i_Layer;
      end
      if (w_accept) begin
        s1_slice_q <= w_slice;
        s1_done_q  <= w_done;
        s1_layer_q <= w_layer;
      end
      if (s1_vld_q) word_q <= s1_done_q ? '0 : w_word;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (w_push) wr_ptr_q <= (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      if (w_pop)  rd_ptr_q <= (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end
  end

  // FIFO storage; contents are don't-care while empty
  always_ff @(posedge CLK) begin
    if (w_push) begin
      mem_q[wr_ptr_q]  <= w_word;
      lmem_q[wr_ptr_q] <= s1_layer_q;
    end
  end

  // Accept only while a slot remains for the word possibly in stage 1
  assign bus.i_Rdy    = (cnt_q <= CNT_W'(FIFO_DEPTH - 2));
  assign bus.o_Vld    = w_nonempty;
  assign bus.o_Data   = w_nonempty ? mem_q[rd_ptr_q] : '0;
  assign bus.o_Layer  = w_nonempty ? lmem_q[rd_ptr_q] : '0;
  assign bus.o_SatCnt = sat_cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_psum_quant_packer.sv
`default_nettype none
// ==========================================================================
// Module   : tb_psum_quant_packer
// Purpose  : Directed self-checking bench for psum_quant_packer.
// Revision : 1.0  initial release
// ==========================================================================
module tb_psum_quant_packer;
  localparam int PSUM_W = 28;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  psum_quant_packer_if bus ();
  psum_quant_packer dut (.CLK(clk), .RST(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [8*PSUM_W-1:0] pk8(input int a0, a1, a2, a3, a4, a5, a6, a7);
    int v [8];
    logic [8*PSUM_W-1:0] r;
    v = '{a0, a1, a2, a3, a4, a5, a6, a7};
    r = '0;
    for (int i = 0; i < 8; i++) r[i*PSUM_W +: PSUM_W] = PSUM_W'(v[i]);
    return r;
  endfunction

  // Present one beat, wait (bounded) for i_Rdy, transfer it on the next edge
  task automatic beat(input logic [1:0] prec, input logic [3:0] sh, input logic relu,
                      input logic last, input logic clr, input logic [4:0] layer,
                      input logic [8*PSUM_W-1:0] psum);
    int n;
    bus.i_Precision = prec;
    bus.i_Shift     = sh;
    bus.i_Relu      = relu;
    bus.i_Last      = last;
    bus.i_Clr       = clr;
    bus.i_Layer     = layer;
    bus.i_Psum      = psum;
    bus.i_Vld       = 1'b1;
    n = 0;
    while (!bus.i_Rdy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("in_rdy", bus.i_Rdy, 1'b1);
    @(posedge clk); #1;
    bus.i_Vld  = 1'b0;
    bus.i_Last = 1'b0;
    bus.i_Clr  = 1'b0;
  endtask

  task automatic pop();
    bus.o_Rdy = 1'b1;
    @(posedge clk); #1;
    bus.o_Rdy = 1'b0;
  endtask

  initial begin
    int acc;
    logic r;
    bus.i_Vld = 0; bus.i_Psum = '0; bus.i_Precision = 0; bus.i_Shift = 0;
    bus.i_Relu = 0; bus.i_Last = 0; bus.i_Layer = 0; bus.i_Clr = 0; bus.o_Rdy = 0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ovld", bus.o_Vld, 1'b0);
    chk("rst_odata", bus.o_Data, 128'h0);
    chk("rst_olayer", bus.o_Layer, 5'd0);
    chk("rst_satcnt", bus.o_SatCnt, 16'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_irdy", bus.i_Rdy, 1'b1);

    // 16b, shift 2: 13 -> 3, -13 -> -3, latency two cycles
    beat(2'd3, 4'd2, 1'b0, 1'b0, 1'b0, 5'd3, pk8(13, -13, 0, 0, 0, 0, 0, 0));
    chk("a_vld_t1", bus.o_Vld, 1'b0);
    @(posedge clk); #1;
    chk("a_vld_t2", bus.o_Vld, 1'b1);
    chk("a_data", bus.o_Data, 128'h0000_0000_0000_0000_0000_0000_FFFD_0003);
    chk("a_layer", bus.o_Layer, 5'd3);
    chk("a_sat", bus.o_SatCnt, 16'd0);
    pop();
    chk("a_empty", bus.o_Vld, 1'b0);

    // 8b two-beat word with saturation both ways
    beat(2'd2, 4'd0, 1'b0, 1'b0, 1'b0, 5'd7, pk8(1000, -1000, 0, 0, 0, 0, 0, 0));
    beat(2'd0, 4'd0, 1'b0, 1'b0, 1'b0, 5'd30, pk8(1, 1, 1, 1, 1, 1, 1, 1));
    @(posedge clk); #1;
    chk("b_vld", bus.o_Vld, 1'b1);
    chk("b_data", bus.o_Data, 128'h0101010101010101_000000000000807F);
    chk("b_layer", bus.o_Layer, 5'd7);
    chk("b_sat", bus.o_SatCnt, 16'd2);
    pop();

    // 2b ReLU eight-beat word; clear coincides with the first increment
    beat(2'd0, 4'd0, 1'b1, 1'b0, 1'b1, 5'd9, pk8(0, 1, 2, 3, 5, -4, 3, 0));
    chk("c_clr_inc", bus.o_SatCnt, 16'd1);
    for (int k = 1; k < 8; k++)
      beat(2'd3, 4'd0, 1'b1, 1'b0, 1'b0, 5'((k == 3) ? 20 : 9), pk8(0, 1, 2, 3, 5, -4, 3, 0));
    @(posedge clk); #1;
    chk("c_vld", bus.o_Vld, 1'b1);
    chk("c_data", bus.o_Data, {8{16'h33E4}});
    chk("c_layer", bus.o_Layer, 5'd9);
    chk("c_sat", bus.o_SatCnt, 16'd8);
    pop();

    // 4b flushed after 3 beats, then a 16b word from index 0
    beat(2'd1, 4'd0, 1'b0, 1'b0, 1'b0, 5'd4, pk8(1, 1, 1, 1, 1, 1, 1, 1));
    beat(2'd1, 4'd0, 1'b0, 1'b0, 1'b0, 5'd4, pk8(2, 2, 2, 2, 2, 2, 2, 2));
    beat(2'd1, 4'd0, 1'b0, 1'b1, 1'b0, 5'd4, pk8(3, 3, 3, 3, 3, 3, 3, 3));
    @(posedge clk); #1;
    chk("d_vld", bus.o_Vld, 1'b1);
    chk("d_data", bus.o_Data, 128'h00000000_33333333_22222222_11111111);
    chk("d_layer", bus.o_Layer, 5'd4);
    pop();
    beat(2'd3, 4'd0, 1'b0, 1'b0, 1'b0, 5'd12, pk8(-1, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    chk("d2_data", bus.o_Data, 128'hFFFF);
    chk("d2_layer", bus.o_Layer, 5'd12);
    pop();

    // 8b ReLU shift 3, single-beat word via i_Last on first beat
    beat(2'd2, 4'd3, 1'b1, 1'b1, 1'b0, 5'd2, pk8(-50, 300, 2100, 12, 0, 0, 0, 0));
    @(posedge clk); #1;
    chk("g_data", bus.o_Data, 128'h02FF2600);
    chk("g_layer", bus.o_Layer, 5'd2);
    chk("g_sat", bus.o_SatCnt, 16'd9);
    pop();

    // Back-pressure: FIFO fills with exactly FIFO_DEPTH words
    bus.i_Precision = 2'd3; bus.i_Shift = 0; bus.i_Relu = 0; bus.i_Last = 0;
    bus.i_Layer = 5'd11; bus.i_Vld = 1'b1;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      bus.i_Psum = pk8(acc + 1, 0, 0, 0, 0, 0, 0, 0);
      r = bus.i_Rdy;
      @(posedge clk); #1;
      if (r) acc++;
    end
    bus.i_Vld = 1'b0;
    chk("e_accepted", 128'(acc), 128'd4);
    chk("e_irdy_low", bus.i_Rdy, 1'b0);
    bus.o_Rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("e_order", bus.o_Data, 128'(k + 1));
      @(posedge clk); #1;
    end
    bus.o_Rdy = 1'b0;
    chk("e_drained", bus.o_Vld, 1'b0);
    chk("e_irdy_back", bus.i_Rdy, 1'b1);

    // Reset mid-word with two words queued
    beat(2'd3, 4'd0, 1'b0, 1'b0, 1'b0, 5'd1, pk8(7, 0, 0, 0, 0, 0, 0, 0));
    beat(2'd3, 4'd0, 1'b0, 1'b0, 1'b0, 5'd1, pk8(8, 0, 0, 0, 0, 0, 0, 0));
    beat(2'd2, 4'd0, 1'b0, 1'b0, 1'b0, 5'd1, pk8(9, 0, 0, 0, 0, 0, 0, 0));
    chk("f_head", bus.o_Data, 128'd7);
    rst_n = 1'b0;
    #1;
    chk("f_rst_vld", bus.o_Vld, 1'b0);
    chk("f_rst_data", bus.o_Data, 128'h0);
    chk("f_rst_layer", bus.o_Layer, 5'd0);
    chk("f_rst_sat", bus.o_SatCnt, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    beat(2'd2, 4'd0, 1'b0, 1'b0, 1'b0, 5'd6, pk8(5, 0, 0, 0, 0, 0, 0, 0));
    beat(2'd2, 4'd0, 1'b0, 1'b0, 1'b0, 5'd6, pk8(-2, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    chk("f_vld", bus.o_Vld, 1'b1);
    chk("f_data", bus.o_Data, 128'h00000000000000FE_0000000000000005);
    chk("f_layer", bus.o_Layer, 5'd6);
    pop();
    chk("f_empty", bus.o_Vld, 1'b0);

    // Saturation counter sticks at all-ones, then clears
    bus.o_Rdy = 1'b1;
    bus.i_Precision = 2'd3; bus.i_Shift = 0; bus.i_Relu = 0; bus.i_Layer = 0;
    bus.i_Psum = pk8(1 << 20, 1 << 20, 1 << 20, 1 << 20, 1 << 20, 1 << 20, 1 << 20, 1 << 20);
    bus.i_Vld = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    chk("h_sat800", bus.o_SatCnt, 16'd800);
    repeat (8200) @(posedge clk);
    #1;
    bus.i_Vld = 1'b0;
    chk("h_sticky", bus.o_SatCnt, 16'hFFFF);
    bus.i_Clr = 1'b1;
    @(posedge clk); #1;
    bus.i_Clr = 1'b0;
    chk("h_clr", bus.o_SatCnt, 16'd0);
    repeat (5) @(posedge clk);
    #1;
    chk("h_drained", bus.o_Vld, 1'b0);
    bus.o_Rdy = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
